// File: rtl/semaphore_lock_master.sv
// rtl/semaphore_lock_master.sv - acquire/release initiator for the semaphore register bank
//
// Purpose:
//   Turns a local acquire/release request into reg-bus transactions.
//   Acquire is read-to-lock: a read returning rdata[0]=1 means the lock is now ours.
//   A failed read waits RETRY_GAP idle cycles and then retries, up to MAX_RETRY reads (0 = forever).
//   Release is a write of 1 to the held lock's address.
//
// Ports:
//   mclk, h_reset_n      clock, asynchronous active-low reset
//   acq_req, lock_id     level acquire request and the lock index it targets
//   rel_req              pulse, release the currently held lock
//   lock_granted         level, lock held
//   acq_fail, rel_done   1-cycle result pulses
//   busy, retry_cnt      status: bus activity pending, failed reads in current acquire
//   reg_cs .. reg_be     registered reg-bus request outputs
//   reg_rdata, reg_ack   reg-bus response inputs
module semaphore_lock_master #(
  parameter int DW        = 16,
  parameter int AW        = $clog2(DW),
  parameter int BW        = $clog2(AW),
  parameter int RETRY_GAP = 8,
  parameter int MAX_RETRY = 15
) (
  input  logic          mclk,
  input  logic          h_reset_n,
  input  logic          acq_req,
  input  logic          rel_req,
  input  logic [AW-1:0] lock_id,
  output logic          lock_granted,
  output logic          acq_fail,
  output logic          rel_done,
  output logic          busy,
  output logic [7:0]    retry_cnt,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic [BW-1:0] reg_be,
  input  logic [DW-1:0] reg_rdata,
  input  logic          reg_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACQ_RD  = 3'd1;
  localparam logic [2:0] S_BACKOFF = 3'd2;
  localparam logic [2:0] S_HELD    = 3'd3;
  localparam logic [2:0] S_REL_WR  = 3'd4;

  localparam logic [AW-1:0] DBG_ADDR = '1;
  localparam int            GW       = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] id_q, id_d;
  logic [7:0]    retry_q, retry_d;
  logic [GW-1:0] backoff_q, backoff_d;
  logic          granted_q, granted_d;
  logic          fail_q, fail_d;
  logic          done_q, done_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] be_q, be_d;

  logic [7:0] retry_inc;
  logic       exhausted;
  logic       unused_rdata;

  assign unused_rdata = ^reg_rdata[DW-1:1];

  assign retry_inc = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
  assign exhausted = (MAX_RETRY != 0) && ((32'(retry_q) + 32'd1) == 32'(MAX_RETRY));

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    retry_d   = retry_q;
    backoff_d = backoff_q;
    granted_d = granted_q;
    fail_d    = 1'b0;
    done_d    = 1'b0;
    // After any fail pulse a still-high acq_req is not re-accepted; the
    // client has to drop it first, otherwise a level request would spin.
    hold_d    = hold_q & acq_req;

    case (state_q)
      S_IDLE: begin
        if (acq_req && !hold_q) begin
          if (lock_id == DBG_ADDR) begin
            fail_d = 1'b1;
            hold_d = 1'b1;
          end else begin
            id_d    = lock_id;
            retry_d = 8'd0;
            state_d = S_ACQ_RD;
          end
        end
      end
      S_ACQ_RD: begin
        if (reg_ack) begin
          if (reg_rdata[0]) begin
            granted_d = 1'b1;
            state_d   = S_HELD;
          end else begin
            retry_d = retry_inc;
            if (exhausted) begin
              fail_d  = 1'b1;
              hold_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              backoff_d = '0;
              state_d   = S_BACKOFF;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (!acq_req) begin
          state_d = S_IDLE;
        end else if (backoff_q == GAP_LAST) begin
          state_d = S_ACQ_RD;
        end else begin
          backoff_d = backoff_q + GW'(1);
        end
      end
      S_HELD: begin
        if (rel_req) begin
          state_d = S_REL_WR;
        end
      end
      S_REL_WR: begin
        if (reg_ack) begin
          granted_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are derived from the next state so they are registered
    // and change together with the state on the same edge.
    cs_d    = (state_d == S_ACQ_RD) || (state_d == S_REL_WR);
    wr_d    = (state_d == S_REL_WR);
    wdata_d = wr_d ? {{(DW-1){1'b0}}, 1'b1} : '0;
    be_d    = wr_d ? '1 : '0;
    busy_d  = (state_d == S_ACQ_RD) || (state_d == S_BACKOFF) || (state_d == S_REL_WR);
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      retry_q   <= '0;
      backoff_q <= '0;
      granted_q <= 1'b0;
      fail_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      retry_q   <= retry_d;
      backoff_q <= backoff_d;
      granted_q <= granted_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  assign lock_granted = granted_q;
  assign acq_fail     = fail_q;
  assign rel_done     = done_q;
  assign busy         = busy_q;
  assign retry_cnt    = retry_q;
  assign reg_cs       = cs_q;
  assign reg_wr       = wr_q;
  assign reg_addr     = id_q;
  assign reg_wdata    = wdata_q;
  assign reg_be       = be_q;

endmodule

// File: tb/tb_semaphore_lock_master.sv
// tb/tb_semaphore_lock_master.sv - scoreboard bench for semaphore_lock_master
module tb_semaphore_lock_master;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int BW   = 2;
  localparam int GAP  = 8;
  localparam int MAXR = 4;

  logic          mclk      = 1'b0;
  logic          h_reset_n = 1'b0;
  logic          acq_req   = 1'b0;
  logic          rel_req   = 1'b0;
  logic [AW-1:0] lock_id   = '0;
  logic          lock_granted, acq_fail, rel_done, busy;
  logic [7:0]    retry_cnt;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [BW-1:0] reg_be;
  logic [DW-1:0] reg_rdata = '0;
  logic          reg_ack   = 1'b0;

  semaphore_lock_master #(.DW(DW), .AW(AW), .BW(BW), .RETRY_GAP(GAP), .MAX_RETRY(MAXR)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n), .acq_req(acq_req), .rel_req(rel_req), .lock_id(lock_id),
    .lock_granted(lock_granted), .acq_fail(acq_fail), .rel_done(rel_done), .busy(busy),
    .retry_cnt(retry_cnt), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  always #5 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 grant, 1 acq_fail, 2 rel_done; -1 fields are not checked
  typedef struct { int kind; int rcnt; int reads; } ev_t;
  ev_t exp_q[$];

  // Responder / semaphore bank model: a read of a free bit sets it and returns 1;
  // a read of a held bit returns 0. An external holder lets go after ext_fails reads.
  logic [DW-1:0] bank = '0;
  int ext_fails  = 0;
  int cs_cnt     = 0;
  int low_run    = 0;
  int reads_acq  = 0;
  int writes_cnt = 0;
  int exp_addr   = 0;
  logic [AW+DW+BW:0] snap;

  initial forever begin
    @(negedge mclk);
    if (!h_reset_n) begin
      bank = '0; ext_fails = 0; cs_cnt = 0; reg_ack = 1'b0; reg_rdata = '0;
    end else if (reg_cs) begin
      cs_cnt++;
      if (cs_cnt == 1) begin
        chk("cs_gap_min", 32'(low_run >= 1), 1);
        if (!reg_wr && reads_acq > 0) chk("retry_gap", 32'(low_run >= GAP), 1);
        chk("bus_addr", 32'(reg_addr), exp_addr);
        chk("bus_wdata", 32'(reg_wdata), reg_wr ? 1 : 0);
        chk("bus_be", 32'(reg_be), reg_wr ? 3 : 0);
        snap = {reg_wr, reg_addr, reg_wdata, reg_be};
        reg_ack = 1'b0;
      end else if (cs_cnt == 2) begin
        chk("bus_stable", 32'({reg_wr, reg_addr, reg_wdata, reg_be}), 32'(snap));
        reg_ack = 1'b1;
        if (reg_wr) begin
          writes_cnt++;
          if (reg_wdata[0]) bank[reg_addr] = 1'b0;
          reg_rdata = '0;
        end else begin
          reads_acq++;
          if (bank[reg_addr]) begin
            reg_rdata = '0;
            if (ext_fails > 0) ext_fails--;
            if (ext_fails == 0) bank[reg_addr] = 1'b0;
          end else begin
            bank[reg_addr] = 1'b1;
            reg_rdata = 16'h0001;
          end
        end
      end else begin
        reg_ack = 1'b0;
      end
      low_run = 0;
    end else begin
      if (cs_cnt != 0) chk("cs_len", cs_cnt, 2);
      cs_cnt = 0; reg_ack = 1'b0; reg_rdata = '0;
      low_run++;
    end
  end

  task automatic check_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      if (e.rcnt >= 0) chk("ev_retry_cnt", 32'(retry_cnt), e.rcnt);
      if (e.reads >= 0) chk("ev_reads", reads_acq, e.reads);
      if (kind == 0) begin
        chk("grant_bank_bit", 32'(bank[exp_addr]), 1);
        chk("grant_not_busy", 32'(busy), 0);
      end
      if (kind == 1) chk("fail_not_granted", 32'(lock_granted), 0);
      if (kind == 2) begin
        chk("rel_bank_bit", 32'(bank[exp_addr]), 0);
        chk("rel_granted_low", 32'(lock_granted), 0);
      end
    end
  endtask

  logic granted_prev = 1'b0, fail_prev = 1'b0, done_prev = 1'b0;

  initial forever begin
    @(negedge mclk);
    if (h_reset_n) begin
      if (lock_granted && !granted_prev) check_ev(0);
      if (acq_fail) begin
        chk("acq_fail_width", 32'(fail_prev), 0);
        check_ev(1);
      end
      if (rel_done) begin
        chk("rel_done_width", 32'(done_prev), 0);
        check_ev(2);
      end
    end
    granted_prev = lock_granted;
    fail_prev    = acq_fail;
    done_prev    = rel_done;
  end

  task automatic wait_events(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge mclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_pending_events", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Reference: an external holder releasing after k failed reads gives a grant
  // with retry_cnt=k and k+1 reads, unless k reaches MAXR, which fails after MAXR reads.
  task automatic do_acq(input int id, input int k_in, input bit both);
    int k = (id == 15) ? 0 : k_in;
    ev_t e;
    reads_acq = 0;
    exp_addr  = id;
    if (k > 0) begin
      bank[id]  = 1'b1;
      ext_fails = k;
    end
    if (id == 15)       e = ev_t'{1, -1, 0};
    else if (k >= MAXR) e = ev_t'{1, MAXR, MAXR};
    else                e = ev_t'{0, k, k + 1};
    exp_q.push_back(e);
    acq_req = 1'b1;
    lock_id = AW'(id);
    if (both) begin
      rel_req = 1'b1;
      @(negedge mclk);
      rel_req = 1'b0;
    end
    wait_events(600);
    acq_req = 1'b0;
    if (e.kind == 0) begin
      repeat ($urandom_range(1, 5)) @(negedge mclk);
      chk("held_granted", 32'(lock_granted), 1);
      chk("held_not_busy", 32'(busy), 0);
      exp_q.push_back(ev_t'{2, -1, -1});
      rel_req = 1'b1;
      @(negedge mclk);
      rel_req = 1'b0;
      wait_events(100);
    end else begin
      if (id != 15) bank[id] = 1'b0;
      ext_fails = 0;
    end
    @(negedge mclk);
  endtask

  initial begin
    int t;
    int w;
    repeat (3) @(negedge mclk);
    chk("reset_ctrl", 32'({lock_granted, acq_fail, rel_done, busy, retry_cnt}), 0);
    chk("reset_bus", 32'({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be}), 0);
    h_reset_n = 1'b1;
    repeat (2) @(negedge mclk);

    do_acq(3, 0, 0);
    do_acq(5, 4, 0);
    do_acq(5, 2, 0);
    do_acq(15, 0, 0);
    do_acq(9, MAXR - 1, 0);
    do_acq(7, 0, 1);

    // acq_req dropped while backing off: back to idle, no fail pulse
    reads_acq = 0; exp_addr = 11; bank[11] = 1'b1; ext_fails = 10;
    acq_req = 1'b1; lock_id = 4'd11;
    t = 0;
    while (!(reads_acq == 1 && !reg_cs && busy) && t < 200) begin
      @(negedge mclk);
      t++;
    end
    chk("backoff_reached", 32'(t < 200), 1);
    acq_req = 1'b0;
    repeat (20) @(negedge mclk);
    chk("backoff_drop_idle", 32'(busy), 0);
    chk("backoff_drop_reads", reads_acq, 1);
    chk("backoff_drop_granted", 32'(lock_granted), 0);
    bank[11] = 1'b0; ext_fails = 0;

    // rel_req in IDLE produces no bus traffic
    w = writes_cnt;
    rel_req = 1'b1;
    @(negedge mclk);
    rel_req = 1'b0;
    repeat (10) @(negedge mclk);
    chk("idle_rel_no_write", writes_cnt, w);
    chk("idle_rel_not_busy", 32'(busy), 0);

    for (int i = 0; i < 24; i++) begin
      int id, k;
      id = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 14));
      k  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
      do_acq(id, k, $urandom_range(0, 3) == 0);
    end

    // reset while a read is on the bus
    reads_acq = 0; exp_addr = 6;
    acq_req = 1'b1; lock_id = 4'd6;
    t = 0;
    while (!reg_cs && t < 50) begin
      @(negedge mclk);
      t++;
    end
    chk("t6_cs_seen", 32'(reg_cs), 1);
    #1 h_reset_n = 1'b0;
    #1;
    chk("t6_reset_ctrl", 32'({lock_granted, acq_fail, rel_done, busy, retry_cnt}), 0);
    chk("t6_reset_bus", 32'({reg_cs, reg_wr, reg_addr, reg_wdata, reg_be}), 0);
    acq_req = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge mclk);
    h_reset_n = 1'b1;
    @(negedge mclk);
    do_acq(6, 0, 0);

    repeat (5) @(negedge mclk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
